// File: rtl/acc_cpu_pkg.sv
// Shared opcode and state encodings for the multi-cycle accumulator CPU.
package acc_cpu_pkg;

   localparam int OP_W = 4;

   typedef enum logic [OP_W-1:0] {
      OP_NOP  = 4'h0,
      OP_LDI  = 4'h1,
      OP_ADD  = 4'h2,
      OP_SUB  = 4'h3,
      OP_AND  = 4'h4,
      OP_OR   = 4'h5,
      OP_XOR  = 4'h6,
      OP_SHL  = 4'h7,
      OP_SHR  = 4'h8,
      OP_JMP  = 4'h9,
      OP_JZ   = 4'hA,
      OP_JC   = 4'hB,
      OP_HALT = 4'hF
   } opcode_e;

   typedef enum logic [1:0] {
      ST_FETCH = 2'd0,
      ST_WAIT  = 2'd1,
      ST_EXEC  = 2'd2,
      ST_HALT  = 2'd3
   } state_e;

endpackage

// File: rtl/acc_cpu_alu.sv
// Combinational ALU: computes the new accumulator and flags for one opcode.
// Opcodes that do not touch the accumulator pass acc through with write_acc_o=0.
module acc_cpu_alu
   import acc_cpu_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic [OP_W-1:0]   opcode_i,
   input  logic [DATA_W-1:0] acc_i,
   input  logic [DATA_W-1:0] imm_i,
   input  logic              flag_c_i,
   output logic [DATA_W-1:0] result_o,
   output logic              carry_o,
   output logic              zero_o,
   output logic              write_acc_o
);

   // Opcode decode; carry defaults to the old flag so LDI leaves it alone.
   always_comb begin
      result_o    = acc_i;
      carry_o     = flag_c_i;
      write_acc_o = 1'b0;
      case (opcode_e'(opcode_i))
         OP_LDI: begin
            result_o    = imm_i;
            write_acc_o = 1'b1;
         end
         OP_ADD: begin
            {carry_o, result_o} = {1'b0, acc_i} + {1'b0, imm_i};
            write_acc_o = 1'b1;
         end
         OP_SUB: begin
            result_o    = acc_i - imm_i;
            carry_o     = (acc_i < imm_i);
            write_acc_o = 1'b1;
         end
         OP_AND: begin
            result_o    = acc_i & imm_i;
            carry_o     = 1'b0;
            write_acc_o = 1'b1;
         end
         OP_OR: begin
            result_o    = acc_i | imm_i;
            carry_o     = 1'b0;
            write_acc_o = 1'b1;
         end
         OP_XOR: begin
            result_o    = acc_i ^ imm_i;
            carry_o     = 1'b0;
            write_acc_o = 1'b1;
         end
         OP_SHL: begin
            result_o    = {acc_i[DATA_W-2:0], 1'b0};
            carry_o     = acc_i[DATA_W-1];
            write_acc_o = 1'b1;
         end
         OP_SHR: begin
            result_o    = {1'b0, acc_i[DATA_W-1:1]};
            carry_o     = acc_i[0];
            write_acc_o = 1'b1;
         end
         default: ;
      endcase
      zero_o = (result_o == '0);
   end

endmodule

// File: rtl/acc_cpu_mc.sv
// Multi-cycle accumulator CPU with handshaked instruction fetch.
//
//  state | meaning
//  FETCH | issue imem_req for pc when run=1, else park
//  WAIT  | hold until imem_valid, then latch ir
//  EXEC  | commit acc/flags/pc from ir, back to FETCH (or HALT)
//  HALT  | terminal, only reset leaves
module acc_cpu_mc
   import acc_cpu_pkg::*;
#(
   parameter  int DATA_W  = 8,
   parameter  int ADDR_W  = 8,
   localparam int INSTR_W = DATA_W + OP_W
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               run,
   output logic               imem_req,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic               imem_valid,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic [DATA_W-1:0]  acc,
   output logic [ADDR_W-1:0]  pc_out,
   output logic [INSTR_W-1:0] ir_out,
   output logic [OP_W-1:0]    alu_op_out,
   output logic [DATA_W-1:0]  alu_result_out,
   output logic               flag_z,
   output logic               flag_c,
   output logic [1:0]         state_out,
   output logic               halted
);

   state_e              state_q;
   logic [ADDR_W-1:0]   pc_q, pc_d;
   logic [INSTR_W-1:0]  ir_q;
   logic [DATA_W-1:0]   acc_q;
   logic                z_q, c_q;

   logic [OP_W-1:0]     op;
   logic [DATA_W-1:0]   imm;
   logic [ADDR_W-1:0]   jmp_tgt;
   logic [DATA_W-1:0]   alu_result;
   logic                alu_carry, alu_zero, alu_write;

   assign op      = ir_q[INSTR_W-1:DATA_W];
   assign imm     = ir_q[DATA_W-1:0];
   assign jmp_tgt = imm[ADDR_W-1:0];

   acc_cpu_alu #(.DATA_W(DATA_W)) u_alu (
      .opcode_i    (op),
      .acc_i       (acc_q),
      .imm_i       (imm),
      .flag_c_i    (c_q),
      .result_o    (alu_result),
      .carry_o     (alu_carry),
      .zero_o      (alu_zero),
      .write_acc_o (alu_write)
   );

   // Next pc for EXEC: sequential increment, taken jumps, or hold on HALT.
   always_comb begin
      pc_d = pc_q + ADDR_W'(1);
      case (opcode_e'(op))
         OP_JMP:  pc_d = jmp_tgt;
         OP_JZ:   if (z_q) pc_d = jmp_tgt;
         OP_JC:   if (c_q) pc_d = jmp_tgt;
         OP_HALT: pc_d = pc_q;
         default: ;
      endcase
   end

   // Control FSM together with the architectural registers it commits.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_FETCH;
         pc_q    <= '0;
         ir_q    <= '0;
         acc_q   <= '0;
         z_q     <= 1'b0;
         c_q     <= 1'b0;
      end else begin
         case (state_q)
            ST_FETCH: if (run) state_q <= ST_WAIT;
            ST_WAIT: begin
               if (imem_valid) begin
                  ir_q    <= imem_rdata;
                  state_q <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               if (alu_write) begin
                  acc_q <= alu_result;
                  z_q   <= alu_zero;
                  c_q   <= alu_carry;
               end
               pc_q    <= pc_d;
               state_q <= (opcode_e'(op) == OP_HALT) ? ST_HALT : ST_FETCH;
            end
            default: ;
         endcase
      end
   end

   // Request is combinational so memory can answer in the very next cycle;
   // masked during reset so a held run does not leak a request.
   assign imem_req       = (state_q == ST_FETCH) && run && !reset;
   assign imem_addr      = pc_q;
   assign acc            = acc_q;
   assign pc_out         = pc_q;
   assign ir_out         = ir_q;
   assign alu_op_out     = op;
   assign alu_result_out = alu_result;
   assign flag_z         = z_q;
   assign flag_c         = c_q;
   assign state_out      = state_q;
   assign halted         = (state_q == ST_HALT);

endmodule
